dmem_responder: RTL and testbench

- Data-memory responder for the RISC-V core's load/store port; it is the memory end of the processor's data interface.
- Accepts one request at a time over a req/ready handshake and inserts a configurable number of wait states.
- Supports byte, halfword and word accesses, with little-endian lane merge on stores and sign/zero extension on loads.
- Flags misaligned, reserved-size and out-of-range accesses with a single-cycle error response.

---
 rtl/dmem_if.sv | 15 +
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the core's load/store unit (master) and data memory (slave).
interface dmem_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, size, uns, addr, wdata, input ready, rdata, err);
    modport slave  (input req, we, size, uns, addr, wdata, output ready, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, byte/half/word access with
// little-endian lane merge, load extension and a one-cycle error response.
module dmem_lane #(
    parameter int LANE  = 0,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          go,
    input  logic [1:0]    size,
    input  logic [1:0]    boff,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    b_byte,
    input  logic [7:0]    b_half,
    input  logic [7:0]    b_word,
    output logic [7:0]    rbyte
);
    localparam logic [1:0] LID = 2'(LANE);

    logic [7:0] mem [DEPTH];
    logic       hit;
    logic [7:0] wbyte;

    always_comb begin
        hit   = 1'b1;
        wbyte = b_word;
        case (size)
            2'b00: begin hit = (boff == LID);       wbyte = b_byte; end
            2'b01: begin hit = (boff[1] == LID[1]); wbyte = b_half; end
            default: ;
        endcase
    end

    always_ff @(posedge clk)
        if (go && hit) mem[idx] <= wbyte;

    assign rbyte = mem[idx];
endmodule

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_if.slave bus
);
    localparam int NUM_LANES = 4;
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [1:0]    boff;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
    } req_t;

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    req_t rq;
    logic err_q, cap_err, wr_go;
    logic [NUM_LANES-1:0][7:0] lane_rd;
    logic [31:0] word, shifted, ld;

    // Size checks plus range check on the full word index, so high address bits cannot alias.
    always_comb begin
        cap_err = 1'b0;
        case (bus.size)
            2'b01:   cap_err = bus.addr[0];
            2'b10:   cap_err = |bus.addr[1:0];
            2'b11:   cap_err = 1'b1;
            default: ;
        endcase
        if (bus.addr[31:2] >= 30'(DEPTH)) cap_err = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            rq    <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.req) begin
                rq    <= '{bus.we, bus.size, bus.uns, bus.addr[1:0], bus.addr[AW+1:2], bus.wdata};
                err_q <= cap_err;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.req) begin
                if (LATENCY == 0) state_nx = RESP;
                else begin
                    state_nx = BUSY;
                    cnt_nx   = 4'(LATENCY);
                end
            end
            BUSY: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write commits on the edge leaving RESP; async reset kills it via state and the explicit gate.
    assign wr_go = (state == RESP) && rq.we && !err_q && !reset;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane #(.LANE(i), .DEPTH(DEPTH), .AW(AW)) u_lane (
            .clk    (clk),
            .go     (wr_go),
            .size   (rq.size),
            .boff   (rq.boff),
            .idx    (rq.idx),
            .b_byte (rq.wdata[7:0]),
            .b_half (rq.wdata[8*(i%2) +: 8]),
            .b_word (rq.wdata[8*i +: 8]),
            .rbyte  (lane_rd[i])
        );
    end

    assign word    = lane_rd;
    assign shifted = word >> {rq.boff, 3'b000};

    always_comb begin
        case (rq.size)
            2'b00:   ld = {{24{shifted[7] & ~rq.uns}}, shifted[7:0]};
            2'b01:   ld = {{16{shifted[15] & ~rq.uns}}, shifted[15:0]};
            default: ld = word;
        endcase
    end

    assign bus.ready = (state == RESP);
    assign bus.err   = (state == RESP) && err_q;
    assign bus.rdata = ((state == RESP) && !rq.we && !err_q) ? ld : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance against a byte-array model.
module tb_dmem_responder;
    localparam int L0 = 2;
    localparam int L1 = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;

    dmem_if b0();
    dmem_if b1();

    dmem_responder #(.DEPTH(64), .LATENCY(L0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    dmem_responder #(.DEPTH(64), .LATENCY(L1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mb [2][256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_bus(input int sel, input logic r, input logic w, input logic [1:0] s,
                           input logic u, input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            b0.req = r; b0.we = w; b0.size = s; b0.uns = u; b0.addr = a; b0.wdata = d;
        end else begin
            b1.req = r; b1.we = w; b1.size = s; b1.uns = u; b1.addr = a; b1.wdata = d;
        end
    endtask

    function automatic logic [33:0] obs(input int sel);
        return (sel == 0) ? {b0.ready, b0.err, b0.rdata} : {b1.ready, b1.err, b1.rdata};
    endfunction

    // Byte-addressed little-endian memory: accesses must be naturally aligned and inside 256 bytes.
    task automatic model(input int sel, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic e);
        int n;
        n  = 1 << s;
        e  = (s == 2'd3) || (a >= 32'd256) || ((a % n) != 0);
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < n; i++) mb[sel][a + i] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd = rd | (32'(mb[sel][a + i]) << (8*i));
                if (!u && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
            end
        end
    endtask

    task automatic op(input int sel, input logic w, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        logic [31:0] erd;
        logic ee;
        logic [33:0] o;
        int lat;
        set_bus(sel, 1'b1, w, s, u, a, d);
        @(posedge clk);
        lat = -1;
        o = '0;
        for (int k = 0; k < 40; k++) begin
            #1;
            o = obs(sel);
            if (o[33]) begin lat = k; break; end
            @(posedge clk);
        end
        set_bus(sel, 1'b0, w, s, u, a, d);
        model(sel, w, s, u, a, d, erd, ee);
        chk("lat", lat, (sel == 0) ? L0 : L1);
        chk("err", 32'(o[32]), 32'(ee));
        chk("rdata", o[31:0], erd);
        rd = o[31:0];
        @(posedge clk);
        #1;
        o = obs(sel);
        chk("rdy_pulse", 32'(o[33]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [33:0] o;
        logic [31:0] ra;
        logic [31:0] pe;
        logic pu;
        int found;
        int rt[$];

        set_bus(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        set_bus(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            o = obs(s);
            chk("rst_ready", 32'(o[33]), 32'd0);
            chk("rst_err", 32'(o[32]), 32'd0);
            chk("rst_rdata", o[31:0], 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) op(s, 1'b1, 2'd2, 1'b0, 32'(i*4), $urandom, rd);

        op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
        op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd);
        chk("lw_10", rd, 32'hDEADBEEF);

        op(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'd0, rd);
        op(0, 1'b1, 2'd0, 1'b0, 32'h23, 32'h80, rd);
        op(0, 1'b0, 2'd0, 1'b0, 32'h23, 32'd0, rd);
        chk("lb_23", rd, 32'hFFFFFF80);
        op(0, 1'b0, 2'd0, 1'b1, 32'h23, 32'd0, rd);
        chk("lbu_23", rd, 32'h00000080);
        op(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd);
        chk("lw_20", rd, 32'h80000000);

        op(0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, rd);
        op(0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000ABCD, rd);
        op(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, rd);
        chk("lw_30", rd, 32'hABCD3344);
        op(0, 1'b0, 2'd1, 1'b0, 32'h32, 32'd0, rd);
        chk("lh_32", rd, 32'hFFFFABCD);
        op(0, 1'b0, 2'd1, 1'b1, 32'h30, 32'd0, rd);
        chk("lhu_30", rd, 32'h00003344);

        op(0, 1'b1, 2'd1, 1'b0, 32'h31, 32'h0000FFFF, rd);
        op(0, 1'b1, 2'd2, 1'b0, 32'h32, 32'hFFFFFFFF, rd);
        op(0, 1'b1, 2'd3, 1'b0, 32'h30, 32'hFFFFFFFF, rd);
        op(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hFFFFFFFF, rd);
        op(0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'd0, rd);
        op(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, rd);
        chk("err_nowrite", rd, 32'hABCD3344);

        // LATENCY=0 instance with req held high across four stores.
        set_bus(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'd0, 32'd1);
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            found = 0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (b1.ready) begin found = 1; break; end
                @(posedge clk);
            end
            chk("b2b_ready", 32'(found), 32'd1);
            rt.push_back(cyc);
            model(1, 1'b1, 2'd2, 1'b0, 32'(j*4), 32'(j+1), pe, pu);
            if (j < 3) set_bus(1, 1'b1, 1'b1, 2'd2, 1'b0, 32'((j+1)*4), 32'(j+2));
            else       set_bus(1, 1'b0, 1'b1, 2'd2, 1'b0, 32'd0, 32'd0);
            @(posedge clk);
        end
        for (int j = 1; j < 4; j++) chk("b2b_gap", 32'(rt[j] - rt[j-1]), 32'd2);
        for (int j = 0; j < 4; j++) begin
            op(1, 1'b0, 2'd2, 1'b0, 32'(j*4), 32'd0, rd);
            chk("b2b_rd", rd, 32'(j+1));
        end

        // Reset while BUSY aborts the store.
        op(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, rd);
        set_bus(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h55);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_bus(0, 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h55);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("rst_busy_rdy", 32'(b0.ready), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        op(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, rd);
        chk("rst_busy_keep", rd, 32'h12345678);

        // Reset during the RESP cycle of a store suppresses the write.
        set_bus(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h99);
        @(posedge clk);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (b0.ready) begin found = 1; break; end
            @(posedge clk);
        end
        chk("resp_seen", 32'(found), 32'd1);
        reset = 1'b1;
        set_bus(0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_resp_rdy", 32'(b0.ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        op(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, rd);
        chk("rst_resp_keep", rd, 32'h12345678);

        for (int n = 0; n < 300; n++) begin
            ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
            op($urandom_range(0, 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ra, $urandom, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
